// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU width, opcode encodings and opcode legality check.
// No ports; imported by the ALU, the arbiter interface and the top.
package alu_pkg;
    localparam int XLEN = 32;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
                          OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND};
    endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request and tagged response channels of the shared ALU.
// Ports (signals): req_valid/req_ready per requester, packed req_s1/req_s2
// (XLEN per requester) and req_op (4 bits per requester); rsp_valid/rsp_ready
// handshake with rsp_data, rsp_id (requester index) and rsp_illegal.
// master = requesters plus response consumer, slave = the arbiter.
interface alu_arbiter_if #(
    parameter int NREQ = 2
);
    import alu_pkg::*;
    localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*XLEN-1:0] req_s1;
    logic [NREQ*XLEN-1:0] req_s2;
    logic [NREQ*4-1:0]    req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [XLEN-1:0]      rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_illegal;

    modport master (
        output req_valid, req_s1, req_s2, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_illegal
    );
    modport slave (
        input  req_valid, req_s1, req_s2, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_illegal
    );
endinterface

// File: rtl/alu.sv
// alu: combinational integer ALU; undefined opcodes produce zero.
// Ports: op (4-bit opcode), s1/s2 (operands), out (result).
module alu
    import alu_pkg::*;
(
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] s1,
    input  logic [XLEN-1:0] s2,
    output logic [XLEN-1:0] out
);
    always_comb begin
        out = '0;
        case (op)
            OP_ADD:  out = s1 + s2;
            OP_SUB:  out = s1 - s2;
            OP_SLL:  out = s1 << s2[4:0];
            OP_SLT:  out = XLEN'($signed(s1) < $signed(s2));
            OP_SLTU: out = XLEN'(s1 < s2);
            OP_XOR:  out = s1 ^ s2;
            OP_SRL:  out = s1 >> s2[4:0];
            OP_SRA:  out = XLEN'($signed(s1) >>> s2[4:0]);
            OP_OR:   out = s1 | s2;
            OP_AND:  out = s1 & s2;
            default: out = '0;
        endcase
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant among NREQ requesters, pointer moves only on advance.
// Ports: clk, rst (sync, active-high), req (request vector), advance (grant was
// taken), grant (one-hot or zero), gnt_idx (index of the granted requester).
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDW  = NREQ > 1 ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gnt_idx
);
    logic [IDW-1:0] last_gnt;

    always_ff @(posedge clk)
        if (rst) last_gnt <= IDW'(NREQ - 1);
        else if (advance) last_gnt <= gnt_idx;

    // Scan from lowest to highest priority so the requester closest after last_gnt is the one left standing.
    always_comb begin
        int j;
        grant   = '0;
        gnt_idx = '0;
        j       = 0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(last_gnt) + k) % NREQ;
            if (|(req & (NREQ'(1) << j))) begin
                grant   = NREQ'(1) << j;
                gnt_idx = IDW'(j);
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU among NREQ requesters with a registered, tagged response.
// Ports: clk, rst (sync, active-high), bus (alu_arbiter_if slave: request
// channels in, response channel out).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IDW  = NREQ > 1 ? $clog2(NREQ) : 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    logic            slot_free;
    logic            advance;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_idx;
    logic [XLEN-1:0] s1;
    logic [XLEN-1:0] s2;
    logic [XLEN-1:0] alu_out;
    logic [3:0]      op;

    // The response register can take a new result if empty or being drained this cycle.
    assign slot_free     = !rst && (!bus.rsp_valid || bus.rsp_ready);
    assign bus.req_ready = slot_free ? grant : '0;
    assign advance       = |bus.req_ready;

    assign s1 = XLEN'(bus.req_s1 >> (int'(gnt_idx) * XLEN));
    assign s2 = XLEN'(bus.req_s2 >> (int'(gnt_idx) * XLEN));
    assign op = 4'(bus.req_op >> (int'(gnt_idx) * 4));

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (advance),
        .grant   (grant),
        .gnt_idx (gnt_idx)
    );

    alu u_alu (
        .op  (op),
        .s1  (s1),
        .s2  (s2),
        .out (alu_out)
    );

    always_ff @(posedge clk)
        if (rst) begin
            bus.rsp_valid   <= 1'b0;
            bus.rsp_data    <= '0;
            bus.rsp_id      <= '0;
            bus.rsp_illegal <= 1'b0;
        end else if (advance) begin
            bus.rsp_valid   <= 1'b1;
            bus.rsp_data    <= alu_out;
            bus.rsp_id      <= gnt_idx;
            bus.rsp_illegal <= !is_legal_op(op);
        end else if (bus.rsp_ready) begin
            bus.rsp_valid   <= 1'b0;
        end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for the two-requester alu_arbiter.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; } rq_t;
    typedef struct { logic [31:0] d; logic id; logic ill; } ex_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NREQ(2)) bus ();
    alu_arbiter #(.NREQ(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    rq_t  q0[$];
    rq_t  q1[$];
    ex_t  sb[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [1:0] fire = 2'b00;
    ex_t  e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic r0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        q0.push_back('{op, a, b});
    endtask

    task automatic r1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        q1.push_back('{op, a, b});
    endtask

    task automatic ex(input logic [31:0] d, input logic id, input logic ill = 1'b0);
        sb.push_back('{d, id, ill});
    endtask

    task automatic drain(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    always @(posedge clk) cyc++;

    // Requester driver: present queue heads, retire an entry once it transferred.
    initial begin
        bus.req_valid = '0;
        bus.req_s1    = '0;
        bus.req_s2    = '0;
        bus.req_op    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (fire[0]) q0.delete(0);
            if (fire[1]) q1.delete(0);
            bus.req_valid = {q1.size() != 0, q0.size() != 0};
            if (q0.size() != 0) begin
                bus.req_s1[31:0] = q0[0].a;
                bus.req_s2[31:0] = q0[0].b;
                bus.req_op[3:0]  = q0[0].op;
            end
            if (q1.size() != 0) begin
                bus.req_s1[63:32] = q1[0].a;
                bus.req_s2[63:32] = q1[0].b;
                bus.req_op[7:4]   = q1[0].op;
            end
        end
    end

    // Monitor: every accepted response is matched against the scoreboard head.
    always @(negedge clk) begin
        fire = bus.req_valid & bus.req_ready;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            pop_cyc.push_back(cyc);
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_data", bus.rsp_data, e.d);
                chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                chk("rsp_illegal", 32'(bus.rsp_illegal), 32'(e.ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_data", bus.rsp_data, 32'd0);
        chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("reset_rsp_illegal", 32'(bus.rsp_illegal), 32'd0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);

        // Tie-break after reset: requester 0 first, one cycle apart.
        @(negedge clk);
        n0 = pop_cyc.size();
        r0(OP_ADD, 32'd5, 32'd7);
        r1(OP_SUB, 32'd5, 32'd7);
        ex(32'd12, 1'b0);
        ex(32'hFFFF_FFFE, 1'b1);
        drain("t1_drain");
        chk("t1_back_to_back", 32'(pop_cyc[$] - pop_cyc[n0]), 32'd1);

        // Sustained contention: strict alternation, one result per cycle.
        @(negedge clk);
        n0 = pop_cyc.size();
        r0(OP_ADD, 32'd1, 32'd2);         r1(OP_SUB, 32'd9, 32'd4);
        r0(OP_ADD, 32'd10, 32'd20);       r1(OP_XOR, 32'hFF, 32'h0F);
        r0(OP_SLL, 32'd3, 32'd4);         r1(OP_AND, 32'hF0F0, 32'hFF00);
        r0(OP_OR, 32'hF0, 32'h0F);        r1(OP_SLTU, 32'd1, 32'd2);
        ex(32'd3, 1'b0);    ex(32'd5, 1'b1);
        ex(32'd30, 1'b0);   ex(32'hF0, 1'b1);
        ex(32'd48, 1'b0);   ex(32'hF000, 1'b1);
        ex(32'hFF, 1'b0);   ex(32'd1, 1'b1);
        drain("t2_drain");
        chk("t2_count", 32'(pop_cyc.size() - n0), 32'd8);
        chk("t2_back_to_back", 32'(pop_cyc[$] - pop_cyc[n0]), 32'd7);

        // Backpressure: stalled response holds and blocks all grants.
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        r0(OP_ADD, 32'd100, 32'd200);
        r0(OP_SUB, 32'd0, 32'd1);
        ex(32'h12C, 1'b0);
        ex(32'hFFFF_FFFF, 1'b0);
        wait_rsp("t3_rsp_wait");
        for (int i = 0; i < 3; i++) begin
            chk("t3_stall_req_ready", 32'(bus.req_ready), 32'd0);
            chk("t3_stall_data", bus.rsp_data, 32'h12C);
            chk("t3_stall_id", 32'(bus.rsp_id), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_req_ready", 32'(bus.req_ready), 32'd1);
        drain("t3_drain");

        // Arithmetic corners and illegal opcodes.
        @(negedge clk);
        r0(OP_SRA, 32'h8000_0000, 32'h24);   ex(32'hF800_0000, 1'b0);
        r0(OP_SLT, 32'hFFFF_FFFF, 32'd1);    ex(32'd1, 1'b0);
        r0(OP_SLTU, 32'hFFFF_FFFF, 32'd1);   ex(32'd0, 1'b0);
        r0(4'b1001, 32'd5, 32'd3);           ex(32'd0, 1'b0, 1'b1);
        r0(OP_SLL, 32'd1, 32'h21);           ex(32'd2, 1'b0);
        r0(OP_SRL, 32'h8000_0000, 32'd31);   ex(32'd1, 1'b0);
        r0(OP_AND, 32'hFF, 32'h0F);          ex(32'h0F, 1'b0);
        r0(OP_ADD, 32'hFFFF_FFFF, 32'd1);    ex(32'd0, 1'b0);
        r0(4'b1111, 32'd7, 32'd7);           ex(32'd0, 1'b0, 1'b1);
        drain("t4_drain");

        // Pointer hold: idle cycles do not disturb the rotation.
        @(negedge clk);
        r1(OP_ADD, 32'd1, 32'd1);
        ex(32'd2, 1'b1);
        drain("t5_first_drain");
        repeat (3) @(posedge clk);
        @(negedge clk);
        r0(OP_XOR, 32'd5, 32'd3);
        r1(OP_SRL, 32'h100, 32'd4);
        ex(32'd6, 1'b0);
        ex(32'h10, 1'b1);
        drain("t5_drain");

        // Reset mid-stall: pending response dropped, pointer back to requester 0 first.
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        r0(OP_ADD, 32'd3, 32'd4);
        wait_rsp("t6_rsp_wait");
        r1(OP_ADD, 32'd9, 32'd9);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.rsp_ready = 1'b1;
        r0(OP_SUB, 32'd10, 32'd3);
        @(negedge clk);
        chk("t6_req_ready_in_rst", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        ex(32'd7, 1'b0);
        ex(32'd18, 1'b1);
        @(negedge clk);
        chk("t6_rsp_valid_after_rst", 32'(bus.rsp_valid), 32'd0);
        chk("t6_req_ready_after_rst", 32'(bus.req_ready), 32'd1);
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
